// File: rtl/dmem_req_ctrl.sv
// MM-stage data-memory request controller: issues cache requests, stalls the
// pipeline until data and instruction fetch both complete, and latches halt.
module dmem_req_ctrl #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   dRENi,
   input  logic                   dWENi,
   input  logic                   halt_i,
   input  logic [31:0]            ALUOut,
   input  logic [31:0]            store,
   input  logic                   ihit,
   input  logic                   dhit,
   input  logic [31:0]            dmemload,
   output logic                   dmemREN,
   output logic                   dmemWEN,
   output logic [31:0]            dmemaddr,
   output logic [31:0]            dmemstore,
   output logic [31:0]            load_data,
   output logic                   pipe_en,
   output logic                   mm_stall,
   output logic                   halt_o,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   output logic [1:0]             dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] hold_q;
   logic        hold_en;
   logic        memop;
   logic        ren, wen, pe, stall;

   assign memop     = dRENi | dWENi;
   assign dmemaddr  = ALUOut;
   assign dmemstore = store;
   assign halt_o    = (state == HALTED);
   assign dbg_state = state;

   // Handshake: a request stays asserted from issue until the cycle dhit
   // returns; dhit is the only acknowledge and is never waited on twice.
   always_comb begin
      state_nxt = state;
      ren       = 1'b0;
      wen       = 1'b0;
      pe        = 1'b0;
      stall     = 1'b0;
      hold_en   = 1'b0;
      load_data = hold_q;
      case (state)
         IDLE, ACCESS: begin
            if (dhit) load_data = dmemload;
            if (memop) begin
               wen = dWENi;
               ren = dRENi & ~dWENi;
               if (dhit) begin
                  if (ihit) begin
                     pe        = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     hold_en   = 1'b1;
                     state_nxt = HOLD;
                  end
               end else begin
                  stall     = 1'b1;
                  state_nxt = ACCESS;
               end
            end else if (state == ACCESS) begin
               // Instruction vanished mid-access: drop it without completing.
               state_nxt = IDLE;
            end else begin
               pe = ihit;
               if (halt_i) state_nxt = HALTED;
            end
         end
         HOLD: begin
            pe = ihit;
            if (ihit) state_nxt = IDLE;
         end
         HALTED: begin
            state_nxt = HALTED;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset must silence the cache interface without waiting for a clock edge.
   assign dmemREN  = ren & nRST;
   assign dmemWEN  = wen & nRST;
   assign pipe_en  = pe & nRST;
   assign mm_stall = stall & nRST;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         hold_q    <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (hold_en) hold_q <= dmemload;
         if (mm_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule

// File: doc/dmem_req_ctrl.md
DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
REQ-001 Parameter: STALL_CNT_W, 16, width of saturating memory-stall cycle counter.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset; asynchronous, active-low.
REQ-004 dRENi  in  1  EX/MM latch: instruction in MM reads memory.
REQ-005 dWENi  in  1  EX/MM latch: instruction in MM writes memory.
REQ-006 halt_i  in  1  EX/MM latch: instruction in MM is halt.
REQ-007 ALUOut  in  32  EX/MM latch: effective address.
REQ-008 store  in  32  EX/MM latch: store data.
REQ-009 ihit  in  1  instruction fetch completed this cycle.
REQ-010 dhit  in  1  data cache completed current request this cycle.
REQ-011 dmemload  in  32  data cache read data, valid when dhit.
REQ-012 dmemREN  out  1  data read request to cache.
REQ-013 dmemWEN  out  1  data write request to cache.
REQ-014 dmemaddr  out  32  data address to cache.
REQ-015 dmemstore  out  32  data to write.
REQ-016 load_data  out  32  load result forwarded to MM/WB latch.
REQ-017 pipe_en  out  1  all pipeline latches advance this cycle.
REQ-018 mm_stall  out  1  MM stage waiting on data memory.
REQ-019 halt_o  out  1  sticky processor halt.
REQ-020 stall_cnt  out  STALL_CNT_W  count of cycles with mm_stall=1.

Function
REQ-021 States: IDLE, ACCESS, HOLD, HALTED; memop = dRENi|dWENi.
REQ-022 dmemaddr=ALUOut and dmemstore=store at all times, combinational.
REQ-023 In IDLE and ACCESS with memop: dmemWEN=dWENi; dmemREN=dRENi&~dWENi (write wins if both set); else both 0.
REQ-024 In HOLD and HALTED: dmemREN=dmemWEN=0.
REQ-025 IDLE, memop, dhit=0 -> ACCESS; request held asserted (same-cycle issue, zero added latency).
REQ-026 IDLE or ACCESS, memop, dhit=1, ihit=1 -> IDLE, pipe_en=1.
REQ-027 IDLE or ACCESS, memop, dhit=1, ihit=0 -> HOLD; dmemload captured into hold register.
REQ-028 ACCESS, dhit=0 -> stay ACCESS regardless of ihit; pipe_en=0.
REQ-029 HOLD: ihit=1 -> IDLE, pipe_en=1; ihit=0 -> stay HOLD, no re-request.
REQ-030 IDLE, no memop: pipe_en=ihit; if halt_i=1 -> HALTED next cycle (ihit ignored for halt).
REQ-031 HALTED: pipe_en=0, halt_o=1, no requests; exits only via reset.
REQ-032 load_data = dmemload when dhit in IDLE/ACCESS; hold register in HOLD; hold register otherwise.
REQ-033 mm_stall=1 exactly when memop and state in {IDLE,ACCESS} and dhit=0.
REQ-034 stall_cnt increments by 1 each cycle mm_stall=1; saturates at all-ones, no wrap.
REQ-035 A request is never reissued for the same instruction after its dhit.

Reset
REQ-036 nRST low immediately: state=IDLE, halt_o=0, stall_cnt=0, hold register=0, dmemREN/dmemWEN forced 0, pipe_en=0.
REQ-037 Reset asserted mid-ACCESS or HOLD abandons the access; no completion reported after release.

Verification
REQ-038 Load, dhit and ihit both in first cycle -> dmemREN=1 one cycle, pipe_en=1 same cycle, state IDLE, stall_cnt=0.
REQ-039 Store, dhit after 3 cycles, ihit=1 throughout -> dmemWEN=1 for 4 cycles, mm_stall=1 for 3, stall_cnt=3, pipe_en=1 on 4th.
REQ-040 Load, dhit with dmemload=0xDEADBEEF while ihit=0, ihit 2 cycles later -> requests drop after dhit, load_data=0xDEADBEEF held, pipe_en=1 on ihit cycle only.
REQ-041 dRENi=dWENi=1 -> dmemWEN=1, dmemREN=0.
REQ-042 halt_i=1, no memop -> halt_o=1 next cycle and forever, pipe_en=0 despite ihit=1; nRST low clears it.
REQ-043 Force 2^STALL_CNT_W+5 stall cycles -> stall_cnt stays 0xFFFF; nRST pulse mid-ACCESS -> dmemREN=0 asynchronously, stall_cnt=0.
